accumulate_unit: RTL and testbench

ACCUMULATE_UNIT -- requirements
Module: accumulate_unit

---
 rtl/accumulate_unit_pkg.sv | 22 ++
 rtl/carry_lookahead_adder.sv | 54 +++++
 rtl/accumulate_unit.sv | 111 +++++++++++
 tb/tb_accumulate_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulate_unit_pkg.sv
// Shared definitions for the packet accumulator.
//   DATA_W      operand / accumulator width
//   CARRY_W     width of the saturating carry-out counter
//   COUNT_W     width of the saturating beat counter
//   SAT_MAX/MIN signed saturation limits
//   state_t     packet state: IDLE (empty), ACC (in progress), DONE (result held)
package accumulate_unit_pkg;

    localparam int DATA_W  = 32;
    localparam int CARRY_W = 8;
    localparam int COUNT_W = 16;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
//   a, b      operands
//   cin       carry in
//   sum       a + b + cin (wrapped to W bits)
//   cout      carry out of the MSB
//   overflow  signed overflow (carry into MSB differs from carry out)
module carry_lookahead_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int NG = W / 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each group resolves its four carries directly from the group carry-in;
    // groups are chained through their carry-out.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            c[4*k+1] = g[4*k]
                     | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign sum      = p ^ c[W-1:0];
    assign cout     = c[W];
    assign overflow = c[W] ^ c[W-1];

endmodule

// File: rtl/accumulate_unit.sv
// Packet accumulator: sums signed 32-bit beats of a packet and presents the
// total with overflow / carry / beat statistics once the last beat arrives.
//   clk, rst      clock, synchronous active-high reset
//   clear         abort the packet in progress (ignored while a result is held)
//   in_valid/in_ready/in_data/in_last   operand beat stream
//   out_valid/out_ready                 result handshake
//   out_sum       accumulator (live in IDLE/ACC, held in DONE)
//   out_ovf       sticky signed overflow for the packet
//   out_carries   adder carry-outs in the packet, saturating at 255
//   out_count     beats accepted in the packet, saturating at 65535
// SATURATE = 0 wraps on overflow, 1 clamps to the signed limits.
module accumulate_unit
    import accumulate_unit_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_sum,
    output logic                      out_ovf,
    output logic [CARRY_W-1:0]        out_carries,
    output logic [COUNT_W-1:0]        out_count
);

    state_t                   state;
    logic signed [DATA_W-1:0] acc;
    logic                     ovf;
    logic [CARRY_W-1:0]       carries;
    logic [COUNT_W-1:0]       count;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              add_ovf;
    logic              accept;

    // Overflow clamps toward the sign of the prior accumulator: on signed
    // overflow both operands share that sign, so it names the limit exceeded.
    function automatic logic [DATA_W-1:0] sat_sum(
        input logic [DATA_W-1:0] sum,
        input logic              prior_sign,
        input logic              overflow
    );
        if (SATURATE && overflow) begin
            return prior_sign ? SAT_MIN : SAT_MAX;
        end
        return sum;
    endfunction

    carry_lookahead_adder #(
        .W (DATA_W)
    ) u_adder (
        .a        (acc),
        .b        (in_data),
        .cin      (1'b0),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            carries <= '0;
            count   <= '0;
        end else if (state == DONE) begin
            // Result is held until taken; clear and beats have no effect here.
            if (out_ready) begin
                state   <= IDLE;
                acc     <= '0;
                ovf     <= 1'b0;
                carries <= '0;
                count   <= '0;
            end
        end else if (clear) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            carries <= '0;
            count   <= '0;
        end else if (accept) begin
            acc <= sat_sum(add_sum, acc[DATA_W-1], add_ovf);
            ovf <= ovf | add_ovf;
            if (add_cout && (carries != '1)) begin
                carries <= carries + 1'b1;
            end
            if (count != '1) begin
                count <= count + 1'b1;
            end
            state <= in_last ? DONE : ACC;
        end
    end

    assign out_sum     = acc;
    assign out_ovf     = ovf;
    assign out_carries = carries;
    assign out_count   = count;

endmodule

// File: tb/tb_accumulate_unit.sv
module tb_accumulate_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [31:0] out_sum0;
    logic [7:0]  out_carries0;
    logic [15:0] out_count0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_sum1;
    logic [7:0]  out_carries1;
    logic [15:0] out_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accumulate_unit #(.SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_ovf(out_ovf0), .out_carries(out_carries0), .out_count(out_count0)
    );

    accumulate_unit #(.SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_ovf(out_ovf1), .out_carries(out_carries1), .out_count(out_count1)
    );

    // {out_valid, in_ready, out_sum, out_ovf, out_carries, out_count}
    logic [58:0] obs [2];
    assign obs[0] = {out_valid0, in_ready0, out_sum0, out_ovf0, out_carries0, out_count0};
    assign obs[1] = {out_valid1, in_ready1, out_sum1, out_ovf1, out_carries1, out_count1};

    // ---------------- reference model (index 0: wrap, 1: saturate) ----------------
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_car [2];
    int     m_cnt [2];
    bit     m_done;

    function automatic logic [58:0] exp_vec(input int s);
        logic [31:0] a;
        logic [7:0]  c;
        logic [15:0] n;
        a = m_acc[s][31:0];
        c = m_car[s][7:0];
        n = m_cnt[s][15:0];
        return {m_done, !m_done, a, m_ovf[s], c, n};
    endfunction

    task automatic model_zero();
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = 0; m_ovf[s] = 0; m_car[s] = 0; m_cnt[s] = 0;
        end
        m_done = 0;
    endtask

    task automatic model_beat(input logic [31:0] data, input bit last);
        longint d, t;
        bit carry, ov;
        d = longint'($signed(data));
        for (int s = 0; s < 2; s++) begin
            t     = m_acc[s] + d;
            carry = ((m_acc[s] & 64'hFFFF_FFFF) + (d & 64'hFFFF_FFFF)) > 64'hFFFF_FFFF;
            ov    = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            if (ov && s == 1) m_acc[s] = (t > 0) ? 64'sd2147483647 : -64'sd2147483648;
            else              m_acc[s] = longint'($signed(t[31:0]));
            if (ov) m_ovf[s] = 1;
            if (carry && m_car[s] < 255) m_car[s]++;
            if (m_cnt[s] < 65535) m_cnt[s]++;
        end
        m_done = last;
    endtask

    // One clock: apply inputs, take the edge, advance the model, settle.
    task automatic drive_cycle(input bit v, input logic [31:0] d, input bit l,
                               input bit clr, input bit ordy);
        in_valid = v; in_data = d; in_last = l; clear = clr; out_ready = ordy;
        @(posedge clk);
        if (m_done) begin
            if (ordy) model_zero();
        end else if (clr) begin
            model_zero();
        end else if (v) begin
            model_beat(d, l);
        end
        #1;
        in_valid = 0; in_last = 0; clear = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        @(posedge clk);
        model_zero();
        #1;
        rst = 0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL reset sat=%0d got=%h exp=%h", s, obs[s], exp_vec(s));
            end
        end
    endtask

    task automatic test_basic_packet();
        logic [31:0] beats [3];
        beats[0] = 32'd5; beats[1] = 32'd7; beats[2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, beats[i], i == 2, 0, 0);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL basic beat%0d sat=%0d got=%h exp=%h", i, s, obs[s], exp_vec(s));
                end
            end
        end
        checks++;
        if ({out_valid0, out_sum0, out_count0, out_ovf0, out_carries0} !==
            {1'b1, 32'd10, 16'd3, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL basic_result got v=%0b sum=%0d cnt=%0d ovf=%0b car=%0d exp v=1 sum=10 cnt=3 ovf=0 car=1",
                     out_valid0, out_sum0, out_count0, out_ovf0, out_carries0);
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        drive_cycle(1, 32'h7FFF_FFFF, 0, 0, 0);
        drive_cycle(1, 32'h1, 1, 0, 0);
        checks++;
        if ({out_sum0, out_ovf0} !== {32'h8000_0000, 1'b1}) begin
            errors++;
            $display("FAIL ovf_wrap got sum=%h ovf=%0b exp sum=80000000 ovf=1", out_sum0, out_ovf0);
        end
        checks++;
        if ({out_sum1, out_ovf1} !== {32'h7FFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sat got sum=%h ovf=%0b exp sum=7fffffff ovf=1", out_sum1, out_ovf1);
        end
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(1, 32'h8000_0000, 0, 0, 0);
        drive_cycle(1, 32'hFFFF_FFFF, 0, 0, 0);
        drive_cycle(1, 32'd5, 1, 0, 0);
        checks++;
        if ({out_sum1, out_ovf1} !== {32'h8000_0005, 1'b1}) begin
            errors++;
            $display("FAIL sat_neg got sum=%h ovf=%0b exp sum=80000005 ovf=1", out_sum1, out_ovf1);
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL sat_neg_vec sat=%0d got=%h exp=%h", s, obs[s], exp_vec(s));
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_hold();
        logic [58:0] held [2];
        drive_cycle(1, 32'd11, 0, 0, 0);
        drive_cycle(1, 32'd22, 1, 0, 0);
        held[0] = obs[0]; held[1] = obs[1];
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1, $urandom, c == 3, c == 2, 0);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== held[s] || obs[s] !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL hold cyc%0d sat=%0d got=%h exp=%h", c, s, obs[s], exp_vec(s));
                end
            end
            checks++;
            if (in_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready got=%0b exp=0", in_ready0);
            end
        end
        drive_cycle(1, 32'd99, 0, 0, 1);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== {2'b01, 57'd0}) begin
                errors++;
                $display("FAIL release sat=%0d got=%h exp=%h", s, obs[s], {2'b01, 57'd0});
            end
        end
    endtask

    task automatic test_clear();
        drive_cycle(1, 32'd3, 0, 0, 0);
        drive_cycle(1, 32'd4, 0, 0, 0);
        drive_cycle(1, 32'd100, 1, 1, 0);
        checks++;
        if (obs[0] !== {2'b01, 57'd0}) begin
            errors++;
            $display("FAIL clear got=%h exp=%h", obs[0], {2'b01, 57'd0});
        end
        drive_cycle(1, 32'd9, 1, 0, 0);
        checks++;
        if ({out_valid0, out_sum0, out_count0} !== {1'b1, 32'd9, 16'd1}) begin
            errors++;
            $display("FAIL after_clear got v=%0b sum=%0d cnt=%0d exp v=1 sum=9 cnt=1",
                     out_valid0, out_sum0, out_count0);
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1, 32'h7FFF_FFF0, 0, 0, 0);
            drive_cycle(1, 32'h100, k == 1, 0, 0);
            in_valid = 1; in_data = 32'd7; clear = 1; out_ready = 1; rst = 1;
            @(posedge clk);
            model_zero();
            #1;
            rst = 0; in_valid = 0; clear = 0; out_ready = 0;
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== {2'b01, 57'd0}) begin
                    errors++;
                    $display("FAIL rst_in_%s sat=%0d got=%h exp=%h", k ? "done" : "acc",
                             s, obs[s], {2'b01, 57'd0});
                end
            end
        end
    endtask

    task automatic test_carry_saturation();
        for (int i = 0; i < 300; i++) drive_cycle(1, 32'hFFFF_FFFF, i == 299, 0, 0);
        checks++;
        if ({out_carries0, out_count0} !== {8'd255, 16'd300}) begin
            errors++;
            $display("FAIL carry_sat got car=%0d cnt=%0d exp car=255 cnt=300", out_carries0, out_count0);
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL carry_sat_vec sat=%0d got=%h exp=%h", s, obs[s], exp_vec(s));
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_count_saturation();
        for (int i = 0; i < 65540; i++) drive_cycle(1, 32'd1, 0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s) || obs[s][15:0] !== 16'hFFFF) begin
                errors++;
                $display("FAIL count_sat sat=%0d got=%h exp=%h", s, obs[s], exp_vec(s));
            end
        end
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 4))
                0: d = 32'h7FFF_FFFF - $urandom_range(0, 3);
                1: d = 32'h8000_0000 + $urandom_range(0, 3);
                2: d = $urandom_range(0, 20) - 10;
                default: d = $urandom;
            endcase
            drive_cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL random cyc%0d sat=%0d got=%h exp=%h", c, s, obs[s], exp_vec(s));
                end
            end
        end
    endtask

    initial begin
        model_zero();
        test_reset();
        test_basic_packet();
        test_overflow();
        test_hold();
        test_clear();
        test_rst_mid();
        test_carry_saturation();
        test_count_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
